// File: rtl/vga_stream_checker.sv
// vga_stream_checker
// Receive-side monitor for the VGA pixel stream. It measures the line length
// (HS fall to HS fall), the lines per frame and the active pixels per frame,
// and checks them against the configured mode. It also sums {B,G,R} over the
// active pixels of each frame and captures one probe pixel at a programmable
// active coordinate. Results are published one clock after a VS fall is
// detected, so oFrameDone rises two clocks after the VS edge on the pin.
//
// Ports:
//   iVGA_CLK, iRST_n      pixel clock, asynchronous active-low reset
//   iHS, iVS              syncs, active low
//   iBLANK_n              1 = active pixel
//   iB, iG, iR            pixel data
//   iProbeX, iProbeY      active coordinate to capture
//   iClrErr               synchronous clear of oErr (new errors win)
//   oFrameDone            one-cycle pulse when frame results update
//   oLineLen              last measured line length
//   oLines, oActivePix    lines / active pixels in the last frame
//   oChecksum             sum mod 2^24 of {B,G,R} over active pixels
//   oProbePix             {B,G,R} captured at the probe coordinate
//   oLocked               last frame matched the configured timing
//   oErr                  sticky: [0] line len, [1] line count,
//                         [2] active count, [3] watchdog
module vga_stream_checker #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int ACTIVE_PIX = 307200,
  parameter int WDOG       = 840000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [7:0]  iB,
  input  logic [7:0]  iG,
  input  logic [7:0]  iR,
  input  logic [9:0]  iProbeX,
  input  logic [8:0]  iProbeY,
  input  logic        iClrErr,
  output logic        oFrameDone,
  output logic [11:0] oLineLen,
  output logic [10:0] oLines,
  output logic [18:0] oActivePix,
  output logic [23:0] oChecksum,
  output logic [23:0] oProbePix,
  output logic        oLocked,
  output logic [3:0]  oErr
);

  localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
  localparam logic [18:0] ACTIVE_L  = 19'(ACTIVE_PIX);
  localparam logic [19:0] WDOG_L    = 20'(WDOG);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, vs_prev_q;
  logic        vs_evt_q, vs_evt_d;
  logic        hs_seen_q, hs_seen_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic [18:0] acnt_q, acnt_d;
  logic [23:0] csum_q, csum_d;
  logic [9:0]  ax_q, ax_d;
  logic [8:0]  ay_q, ay_d;
  logic        line_act_q, line_act_d;
  logic        line_err_q, line_err_d;
  logic [19:0] wdog_q, wdog_d;
  logic [23:0] probe_q, probe_d;
  logic        frame_done_q, frame_done_d;
  logic [11:0] line_len_q, line_len_d;
  logic [10:0] lines_q, lines_d;
  logic [18:0] act_pix_q, act_pix_d;
  logic [23:0] checksum_q, checksum_d;
  logic [23:0] probe_pix_q, probe_pix_d;
  logic        locked_q, locked_d;
  logic [3:0]  err_q, err_d;

  logic        hs_fall_s, vs_fall_s, pix_en_s, len_bad_s, match_s;
  logic [23:0] pix_s;
  logic [3:0]  err_set_s;

  // Next-state logic for the measurement datapath and the SEEK/MEASURE/LOCKED FSM
  always_comb begin
    hs_fall_s    = hs_prev_q & ~iHS;
    vs_fall_s    = vs_prev_q & ~iVS;
    pix_s        = {iB, iG, iR};
    pix_en_s     = iBLANK_n & (state_q != SEEK);
    len_bad_s    = hs_fall_s & hs_seen_q & (state_q != SEEK) &
                   ((hcnt_q + 12'd1) != H_TOTAL_L);
    match_s      = 1'b0;
    err_set_s    = 4'd0;
    vs_evt_d     = vs_fall_s;
    hs_seen_d    = hs_seen_q | hs_fall_s;
    hcnt_d       = hcnt_q + 12'd1;
    state_d      = state_q;
    probe_d      = probe_q;
    frame_done_d = 1'b0;
    line_len_d   = line_len_q;
    lines_d      = lines_q;
    act_pix_d    = act_pix_q;
    checksum_d   = checksum_q;
    probe_pix_d  = probe_pix_q;
    locked_d     = locked_q;

    // A processed VS fall starts a fresh frame; this cycle's sample then
    // belongs to the new frame, the cycle of the pin edge to the old one.
    if (vs_evt_q) begin
      lcnt_d     = 11'd0;
      acnt_d     = 19'd0;
      csum_d     = 24'd0;
      ax_d       = 10'd0;
      ay_d       = 9'd0;
      line_act_d = 1'b0;
      line_err_d = 1'b0;
      wdog_d     = 20'd0;
    end else begin
      lcnt_d     = lcnt_q;
      acnt_d     = acnt_q;
      csum_d     = csum_q;
      ax_d       = ax_q;
      ay_d       = ay_q;
      line_act_d = line_act_q;
      line_err_d = line_err_q;
      wdog_d     = (wdog_q == WDOG_L) ? wdog_q : (wdog_q + 20'd1);
    end

    // Line boundary: the row index only advances past lines that carried pixels
    if (hs_fall_s) begin
      line_len_d = hcnt_q + 12'd1;
      hcnt_d     = 12'd0;
      lcnt_d     = lcnt_d + 11'd1;
      ay_d       = line_act_d ? (ay_d + 9'd1) : ay_d;
      ax_d       = 10'd0;
      line_act_d = 1'b0;
      line_err_d = line_err_d | len_bad_s;
      err_set_s[0] = len_bad_s;
    end else begin
      line_len_d = line_len_q;
    end

    if (pix_en_s) begin
      acnt_d     = acnt_d + 19'd1;
      csum_d     = csum_d + pix_s;
      probe_d    = ((ax_d == iProbeX) && (ay_d == iProbeY)) ? pix_s : probe_q;
      ax_d       = ax_d + 10'd1;
      line_act_d = 1'b1;
    end else begin
      probe_d    = probe_q;
    end

    case (state_q)
      SEEK: begin
        if (vs_evt_q) begin
          state_d = MEASURE;
        end else begin
          state_d = SEEK;
        end
      end
      MEASURE, LOCKED: begin
        if (vs_evt_q) begin
          lines_d      = lcnt_q;
          act_pix_d    = acnt_q;
          checksum_d   = csum_q;
          probe_pix_d  = probe_q;
          frame_done_d = 1'b1;
          err_set_s[1] = (lcnt_q != V_TOTAL_L);
          err_set_s[2] = (acnt_q != ACTIVE_L);
          match_s      = (lcnt_q == V_TOTAL_L) && (acnt_q == ACTIVE_L) && !line_err_q;
          locked_d     = match_s;
          state_d      = match_s ? LOCKED : MEASURE;
        end else if (wdog_q == WDOG_L) begin
          err_set_s[3] = 1'b1;
          locked_d     = 1'b0;
          state_d      = SEEK;
        end else begin
          state_d      = state_q;
        end
      end
      default: begin
        state_d  = SEEK;
        locked_d = 1'b0;
      end
    endcase

    // Clear first, then let errors raised this same cycle survive
    err_d = (iClrErr ? 4'd0 : err_q) | err_set_s;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= SEEK;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      vs_evt_q     <= 1'b0;
      hs_seen_q    <= 1'b0;
      hcnt_q       <= 12'd0;
      lcnt_q       <= 11'd0;
      acnt_q       <= 19'd0;
      csum_q       <= 24'd0;
      ax_q         <= 10'd0;
      ay_q         <= 9'd0;
      line_act_q   <= 1'b0;
      line_err_q   <= 1'b0;
      wdog_q       <= 20'd0;
      probe_q      <= 24'd0;
      frame_done_q <= 1'b0;
      line_len_q   <= 12'd0;
      lines_q      <= 11'd0;
      act_pix_q    <= 19'd0;
      checksum_q   <= 24'd0;
      probe_pix_q  <= 24'd0;
      locked_q     <= 1'b0;
      err_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      hs_prev_q    <= iHS;
      vs_prev_q    <= iVS;
      vs_evt_q     <= vs_evt_d;
      hs_seen_q    <= hs_seen_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      acnt_q       <= acnt_d;
      csum_q       <= csum_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      line_act_q   <= line_act_d;
      line_err_q   <= line_err_d;
      wdog_q       <= wdog_d;
      probe_q      <= probe_d;
      frame_done_q <= frame_done_d;
      line_len_q   <= line_len_d;
      lines_q      <= lines_d;
      act_pix_q    <= act_pix_d;
      checksum_q   <= checksum_d;
      probe_pix_q  <= probe_pix_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign oFrameDone = frame_done_q;
  assign oLineLen   = line_len_q;
  assign oLines     = lines_q;
  assign oActivePix = act_pix_q;
  assign oChecksum  = checksum_q;
  assign oProbePix  = probe_pix_q;
  assign oLocked    = locked_q;
  assign oErr       = err_q;

endmodule

// File: tb/tb_vga_stream_checker.sv
// Randomized bench for vga_stream_checker using a reduced video mode.
// Frames are generated geometrically (HS low at the start of each line,
// VS low for the first lines of a frame, a rectangular active window) and the
// expected frame results are computed from what was driven.
module tb_vga_stream_checker;

  localparam int HT  = 40;
  localparam int VT  = 20;
  localparam int AW  = 16;
  localparam int AH  = 12;
  localparam int AP  = AW * AH;
  localparam int WD  = 2000;
  localparam int HSW = 4;
  localparam int HA0 = 8;
  localparam int VA0 = 3;
  localparam int VSW = 2;

  logic        clk = 1'b0;
  logic        iRST_n, iHS, iVS, iBLANK_n, iClrErr;
  logic [7:0]  iB, iG, iR;
  logic [9:0]  iProbeX;
  logic [8:0]  iProbeY;
  logic        oFrameDone, oLocked;
  logic [11:0] oLineLen;
  logic [10:0] oLines;
  logic [18:0] oActivePix;
  logic [23:0] oChecksum, oProbePix;
  logic [3:0]  oErr;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit          m_meas;
  bit          m_locked;
  logic [3:0]  m_err;
  logic [23:0] m_probe;
  int          m_last_len;
  int          pf_lines, pf_act;
  logic [23:0] pf_csum;
  bit          pf_lerr;

  always #5 clk = ~clk;

  vga_stream_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .ACTIVE_PIX(AP), .WDOG(WD)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
    .iB(iB), .iG(iG), .iR(iR), .iProbeX(iProbeX), .iProbeY(iProbeY),
    .iClrErr(iClrErr), .oFrameDone(oFrameDone), .oLineLen(oLineLen),
    .oLines(oLines), .oActivePix(oActivePix), .oChecksum(oChecksum),
    .oProbePix(oProbePix), .oLocked(oLocked), .oErr(oErr)
  );

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk_val({tag, "_done"},   32'(oFrameDone), 32'd0);
    chk_val({tag, "_linelen"}, 32'(oLineLen),  32'd0);
    chk_val({tag, "_lines"},  32'(oLines),     32'd0);
    chk_val({tag, "_act"},    32'(oActivePix), 32'd0);
    chk_val({tag, "_csum"},   32'(oChecksum),  32'd0);
    chk_val({tag, "_probe"},  32'(oProbePix),  32'd0);
    chk_val({tag, "_locked"}, 32'(oLocked),    32'd0);
    chk_val({tag, "_err"},    32'(oErr),       32'd0);
  endtask

  task automatic model_reset;
    m_meas     = 1'b0;
    m_locked   = 1'b0;
    m_err      = 4'd0;
    m_probe    = 24'd0;
    m_last_len = HT;
  endtask

  task automatic idle(input int n);
    iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iClrErr = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (oFrameDone) chk_val("idle_done", 32'(oFrameDone), 32'd0);
    end
  endtask

  // Drive one frame. pmode: 0 = all 1, 1 = {row,col} gradient, 2 = all FFFFFF,
  // 3 = random. vs_on = 0 keeps VS high (the previous frame just continues).
  task automatic run_frame(input int nlines, input int stretch, input int drop_row,
                           input int pmode, input int clr_line, input bit vs_on,
                           input int px, input int py);
    int          c, f_act, llen;
    logic [23:0] f_csum, pix;
    bit          f_lerr, act, pub;
    c = 0; f_act = 0; f_csum = 24'd0; f_lerr = 1'b0; pub = 1'b0;
    iProbeX = px[9:0];
    iProbeY = py[8:0];
    for (int l = 0; l < nlines; l++) begin
      llen = (l == stretch) ? HT + 1 : HT;
      for (int h = 0; h < llen; h++) begin
        act = (l >= VA0) && (l < VA0 + AH) && (h >= HA0) && (h < HA0 + AW) &&
              !((l - VA0 == drop_row) && (h == HA0 + AW - 1));
        case (pmode)
          0:       pix = 24'h000001;
          1:       pix = {5'd0, 9'(l - VA0), 10'(h - HA0)};
          2:       pix = 24'hFFFFFF;
          default: pix = 24'($urandom);
        endcase
        iHS      = (h < HSW) ? 1'b0 : 1'b1;
        iVS      = (vs_on && (l < VSW)) ? 1'b0 : 1'b1;
        iBLANK_n = act;
        {iB, iG, iR} = act ? pix : 24'($urandom);
        iClrErr  = (h == 0) && (l == clr_line);
        if (iClrErr) m_err = 4'd0;
        // the line ending at this HS fall is judged only while measuring
        if (h == 0 && m_meas && m_last_len != HT) begin
          m_err[0] = 1'b1;
          if (l == 0 && vs_on) pf_lerr = 1'b1;
          else f_lerr = 1'b1;
        end
        if (c == 1 && vs_on) begin
          if (m_meas) begin
            pub = 1'b1;
            if (pf_lines != VT) m_err[1] = 1'b1;
            if (pf_act != AP) m_err[2] = 1'b1;
            m_locked = (pf_lines == VT) && (pf_act == AP) && !pf_lerr;
          end
          m_meas = 1'b1;
        end
        if (act && m_meas) begin
          f_act++;
          f_csum = f_csum + pix;
          if ((l - VA0 == py) && (h - HA0 == px)) m_probe = pix;
        end
        tick;
        if (c == 1 && vs_on) begin
          chk_val("frame_done", 32'(oFrameDone), 32'(pub));
          if (pub) begin
            chk_val("lines",   32'(oLines),     32'(pf_lines));
            chk_val("act_pix", 32'(oActivePix), 32'(pf_act));
            chk_val("csum",    32'(oChecksum),  32'(pf_csum));
            chk_val("probe",   32'(oProbePix),  32'(m_probe));
            chk_val("linelen", 32'(oLineLen),   32'(m_last_len));
            chk_val("locked",  32'(oLocked),    32'(m_locked));
            chk_val("err",     32'(oErr),       32'(m_err));
          end
        end else if (oFrameDone) begin
          chk_val("done_extra", 32'(oFrameDone), 32'd0);
        end
        if (iClrErr) chk_val("err_clr", 32'(oErr), 32'(m_err));
        c++;
      end
      m_last_len = llen;
    end
    iClrErr = 1'b0;
    pf_lines = nlines;
    pf_act   = f_act;
    pf_csum  = f_csum;
    pf_lerr  = f_lerr;
    // VS never fell: the watchdog expires and the checker falls back to SEEK
    if (!vs_on && m_meas && c > WD) begin
      m_err[3] = 1'b1;
      m_meas   = 1'b0;
      m_locked = 1'b0;
    end
  endtask

  initial begin
    iRST_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iClrErr = 1'b0;
    iB = 8'd0; iG = 8'd0; iR = 8'd0; iProbeX = 10'd0; iProbeY = 9'd0;
    model_reset();
    pf_lines = 0; pf_act = 0; pf_csum = 24'd0; pf_lerr = 1'b0;
    #1;
    chk_zero("rst");
    repeat (3) tick;
    iRST_n = 1'b1;
    idle(5);

    // nominal lock, gradient probe at the last active pixel, checksum wrap
    run_frame(VT, -1, -1, 0, -1, 1'b1, 0, 0);
    run_frame(VT, -1, -1, 1, -1, 1'b1, AW - 1, AH - 1);
    run_frame(VT, -1, -1, 2, -1, 1'b1, 3, 2);
    // random pixels and probes, the last one outside the active window
    run_frame(VT, -1, -1, 3, -1, 1'b1, $urandom_range(AW - 1, 0), $urandom_range(AH - 1, 0));
    run_frame(VT, -1, -1, 3, -1, 1'b1, $urandom_range(AW - 1, 0), $urandom_range(AH - 1, 0));
    run_frame(VT, -1, -1, 3, -1, 1'b1, 700, 5);
    // short frame, dropped pixel, recovery
    run_frame(VT - 1, -1, -1, 3, -1, 1'b1, 1, 1);
    run_frame(VT, -1, $urandom_range(AH - 1, 0), 3, -1, 1'b1, 2, 2);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 4, 4);
    // stretched line with a clear in the same cycle the error is raised
    run_frame(VT, 5, -1, 3, 6, 1'b1, 5, 5);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 6, 6);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 7, 7);
    run_frame(VT, -1, -1, 3, 8, 1'b1, 8, 8);
    // watchdog: VS stops, then a discarded frame and relock
    run_frame(60, -1, -1, 3, -1, 1'b0, 9, 9);
    chk_val("wdog_err",    32'(oErr),    32'(m_err));
    chk_val("wdog_locked", 32'(oLocked), 32'(m_locked));
    run_frame(VT, -1, -1, 3, -1, 1'b1, 1, 2);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 2, 3);
    run_frame(VT, -1, -1, 0, -1, 1'b1, 0, 0);
    // reset in the middle of a frame
    run_frame(10, -1, -1, 3, -1, 1'b1, 0, 0);
    iRST_n = 1'b0;
    #2;
    chk_zero("midrst");
    repeat (2) tick;
    chk_zero("midrst_hold");
    iRST_n = 1'b1;
    model_reset();
    idle(5);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 3, 3);
    run_frame(VT, -1, -1, 3, -1, 1'b1, 4, 4);
    run_frame(VT, -1, -1, 0, -1, 1'b1, 0, 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
